// File: rtl/hiscore_upload.sv
// hiscore_upload: serves hps_io upload reads from the core work-RAM window
// (high-score / NVRAM area), pausing the game CPU for the whole session.
// Optional feature macro: HISCORE_CHECKSUM_EN. When defined, a checksum
// sweep runs after the pause is granted, and byte SIZE returns the value
// that makes all SIZE+1 exported bytes total 0 mod 256.
//
// Host handshake: ioctl_rd is a one-cycle request that is honoured only
// while ioctl_wait is low (READY). ioctl_wait rises the cycle after an
// in-range request and falls in the same cycle that ioctl_din carries the
// byte. Out-of-range requests complete the next cycle without raising
// ioctl_wait. Requests made while ioctl_wait is high are ignored.
module hiscore_upload #(
  parameter int AW     = 10,
  parameter int SIZE   = 64,
  parameter int RD_LAT = 1,
  parameter int ACK_TO = 4096
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_upload,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          pause_req,
  input  logic          pause_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd,
  input  logic [7:0]    ram_q,
  output logic          ack_timeout,
  output logic          done,
  output logic [2:0]    dbg_state
);

  // One counter serves the ack timeout, the fetch latency and the sweep.
  localparam int ACK_W = $clog2(ACK_TO) + 1;
  localparam int SUM_W = AW + 3;
  localparam int CW    = (ACK_W > SUM_W) ? ACK_W : SUM_W;

  localparam logic [CW-1:0] ACK_LAST   = CW'(ACK_TO - 1);
  localparam logic [CW-1:0] FETCH_LAST = CW'(RD_LAT);
  localparam logic [24:0]   SIZE_A     = 25'(SIZE);
`ifdef HISCORE_CHECKSUM_EN
  localparam logic [CW-1:0] SUM_ISSUE_END = CW'(SIZE - 1);
  localparam logic [CW-1:0] SUM_ACC_FROM  = CW'(RD_LAT);
  localparam logic [CW-1:0] SUM_LAST      = CW'(SIZE - 1 + RD_LAT);
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PAUSE = 3'd1,
    S_READY = 3'd2,
    S_FETCH = 3'd3
`ifdef HISCORE_CHECKSUM_EN
    , S_SUM = 3'd4
`endif
  } state_t;

  state_t        state, state_n;
  logic          upload_q;
  logic [CW-1:0] cnt;
  logic [7:0]    fill_byte;

  // Control strobes from the FSM to the datapath registers.
  logic          issue_rd;
  logic [AW-1:0] issue_addr;
  logic          cnt_clr, cnt_inc;
  logic          latch_q, load_fill;
  logic          set_to, clr_to;
  logic          pulse_done;

`ifdef HISCORE_CHECKSUM_EN
  logic [7:0]    sum;
  logic          acc_sum, clr_sum;
  logic [CW-1:0] cnt_plus1;
  assign cnt_plus1 = cnt + CW'(1);
`endif

  // Fill byte for requests outside the RAM window.
`ifdef HISCORE_CHECKSUM_EN
  assign fill_byte = (ioctl_addr == SIZE_A) ? (8'd0 - sum) : 8'hFF;
`else
  assign fill_byte = 8'hFF;
`endif

  // State register.
  always_ff @(posedge clk_sys) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state logic, control strobes and state-decoded outputs.
  always_comb begin
    state_n    = state;
    issue_rd   = 1'b0;
    issue_addr = '0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    latch_q    = 1'b0;
    load_fill  = 1'b0;
    set_to     = 1'b0;
    clr_to     = 1'b0;
    pulse_done = 1'b0;
`ifdef HISCORE_CHECKSUM_EN
    acc_sum    = 1'b0;
    clr_sum    = 1'b0;
`endif
    pause_req  = (state != S_IDLE);
    ioctl_wait = (state == S_PAUSE) || (state == S_FETCH)
`ifdef HISCORE_CHECKSUM_EN
                 || (state == S_SUM)
`endif
                 ;
    dbg_state  = state;

    // Session end wins over everything; any in-flight read is dropped.
    if ((state != S_IDLE) && !ioctl_upload) begin
      state_n    = S_IDLE;
      pulse_done = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (ioctl_upload && !upload_q) begin
            state_n = S_PAUSE;
            cnt_clr = 1'b1;
            clr_to  = 1'b1;
          end
        end
        S_PAUSE: begin
          // A late ack on the final count still counts as an ack.
          if (pause_ack || (cnt == ACK_LAST)) begin
            set_to  = !pause_ack;
            cnt_clr = 1'b1;
`ifdef HISCORE_CHECKSUM_EN
            state_n    = S_SUM;
            issue_rd   = 1'b1;
            issue_addr = '0;
            clr_sum    = 1'b1;
`else
            state_n    = S_READY;
`endif
          end else begin
            cnt_inc = 1'b1;
          end
        end
`ifdef HISCORE_CHECKSUM_EN
        S_SUM: begin
          // cnt counts sweep cycles; issue i is returned at cnt = i + RD_LAT.
          cnt_inc = 1'b1;
          if (cnt < SUM_ISSUE_END) begin
            issue_rd   = 1'b1;
            issue_addr = cnt_plus1[AW-1:0];
          end
          if (cnt >= SUM_ACC_FROM) acc_sum = 1'b1;
          if (cnt == SUM_LAST)     state_n = S_READY;
        end
`endif
        S_READY: begin
          if (ioctl_rd) begin
            if (ioctl_addr < SIZE_A) begin
              issue_rd   = 1'b1;
              issue_addr = ioctl_addr[AW-1:0];
              cnt_clr    = 1'b1;
              state_n    = S_FETCH;
            end else begin
              load_fill = 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (cnt == FETCH_LAST) begin
            latch_q = 1'b1;
            state_n = S_READY;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Datapath registers driven by the FSM strobes.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      upload_q    <= 1'b0;
      cnt         <= '0;
      ram_rd      <= 1'b0;
      ram_addr    <= '0;
      ioctl_din   <= 8'h00;
      ack_timeout <= 1'b0;
      done        <= 1'b0;
`ifdef HISCORE_CHECKSUM_EN
      sum         <= 8'h00;
`endif
    end else begin
      upload_q <= ioctl_upload;
      ram_rd   <= issue_rd;
      done     <= pulse_done;
      if (issue_rd) ram_addr <= issue_addr;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CW'(1);
      if (latch_q)        ioctl_din <= ram_q;
      else if (load_fill) ioctl_din <= fill_byte;
      if (clr_to)      ack_timeout <= 1'b0;
      else if (set_to) ack_timeout <= 1'b1;
`ifdef HISCORE_CHECKSUM_EN
      if (clr_sum)      sum <= 8'h00;
      else if (acc_sum) sum <= sum + ram_q;
`endif
    end
  end

endmodule
